// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one registered 8-bit adder among N_REQ requesters.
// Accept-to-response latency ADDER_LAT+1 clocks; a stalled response blocks all new grants.
module adder_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int ADDER_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_a,
  input  logic [8*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           A,
  output logic [7:0]           B,
  input  logic [7:0]           sum,
  input  logic                 carry,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_sum,
  output logic                 rsp_carry,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr, ptr_inc, op_id;
  logic [2:0]      cnt;
  logic            grant_vld, accept, capture;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W:0]   idx_w;
  logic [7:0]      sel_a, sel_b;

  // Scan offsets high-to-low so the nearest valid requester at or after ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx_w     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx_w = {1'b0, ptr} + (ID_W+1)'(k);
      if (idx_w >= (ID_W+1)'(N_REQ))
        idx_w = idx_w - (ID_W+1)'(N_REQ);
      if (req_valid[idx_w[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = idx_w[ID_W-1:0];
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = req_a[8*i +: 8];
        sel_b = req_b[8*i +: 8];
      end
    end
  end

  assign ptr_inc = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so no grant is advertised while the block is held in reset.
        if (grant_vld && rst_n) begin
          for (int i = 0; i < N_REQ; i++)
            req_ready[i] = (grant_idx == ID_W'(i));
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 3'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A         <= '0;
      B         <= '0;
      ptr       <= '0;
      op_id     <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
    end else begin
      if (accept) begin
        A     <= sel_a;
        B     <= sel_b;
        op_id <= grant_idx;
        ptr   <= ptr_inc;
        cnt   <= 3'(ADDER_LAT);
      end else if (state == WAIT && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      if (capture) begin
        rsp_valid <= 1'b1;
        rsp_id    <= op_id;
        rsp_sum   <= sum;
        rsp_carry <= carry;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a one-clock registered adder model.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic [7:0]  A, B, sum;
  logic        carry;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_sum;
  logic        rsp_carry, busy;

  int n_vec = 0;
  int n_err = 0;

  adder_arbiter #(.N_REQ(4), .ID_W(2), .ADDER_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .A(A), .B(B), .sum(sum), .carry(carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .busy(busy)
  );

  always #5 clk = ~clk;

  // Registered adder: result valid one clock after operands change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {carry, sum} <= 9'd0;
    else        {carry, sum} <= {1'b0, A} + {1'b0, B};
  end

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  id;
    logic [7:0]  sum;
    logic        carry;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction; with hold=1 the response is left pending (rsp_ready=0).
  task automatic apply_vec(input vec_t v, input bit hold);
    int         cyc;
    logic [3:0] oh;
    oh        = 4'b0001 << v.id;
    rsp_ready = !hold;
    req_a     = v.a;
    req_b     = v.b;
    req_valid = v.valid;
    #1;
    cyc = 0;
    while (req_ready == 4'b0 && cyc < 10) begin
      step();
      cyc++;
    end
    chk("grant", {28'd0, req_ready}, {28'd0, oh});
    if (req_ready != 4'b0) begin
      step();
      req_valid = 4'b0;
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
      chk("A_load", {24'd0, A}, {24'd0, v.a[8*v.id +: 8]});
      chk("B_load", {24'd0, B}, {24'd0, v.b[8*v.id +: 8]});
      cyc = 0;
      do begin
        step();
        cyc++;
      end while (!rsp_valid && cyc < 10);
      chk("latency", cyc, 32'd2);
      chk("rsp_id", {30'd0, rsp_id}, {30'd0, v.id});
      chk("rsp_sum", {24'd0, rsp_sum}, {24'd0, v.sum});
      chk("rsp_carry", {31'd0, rsp_carry}, {31'd0, v.carry});
      if (!hold) begin
        step();
        chk("rsp_valid_clear", {31'd0, rsp_valid}, 32'd0);
      end
    end
  endtask

  initial begin
    bit seen;
    vec_t bp, rv;
    tbl[0]  = '{4'b0001, 32'h0000_000F, 32'h0000_0001, 2'd0, 8'h10, 1'b0};
    tbl[1]  = '{4'b0100, 32'h00FF_0000, 32'h0002_0000, 2'd2, 8'h01, 1'b1};
    tbl[2]  = '{4'b1000, 32'h8000_0000, 32'h8000_0000, 2'd3, 8'h00, 1'b1};
    for (int i = 0; i < 8; i++) begin
      tbl[3+i].valid = 4'b1111;
      tbl[3+i].a     = 32'h4433_2211;
      tbl[3+i].b     = 32'hF00E_E005;
      tbl[3+i].id    = 2'(i % 4);
      case (i % 4)
        0:       begin tbl[3+i].sum = 8'h16; tbl[3+i].carry = 1'b0; end
        1:       begin tbl[3+i].sum = 8'h02; tbl[3+i].carry = 1'b1; end
        2:       begin tbl[3+i].sum = 8'h41; tbl[3+i].carry = 1'b0; end
        default: begin tbl[3+i].sum = 8'h34; tbl[3+i].carry = 1'b1; end
      endcase
    end
    tbl[11] = '{4'b0100, 32'h0055_0000, 32'h00AA_0000, 2'd2, 8'hFF, 1'b0};
    tbl[12] = '{4'b1001, 32'h0100_007F, 32'h0100_0081, 2'd3, 8'h02, 1'b0};
    tbl[13] = '{4'b1001, 32'h0100_007F, 32'h0100_0081, 2'd0, 8'h00, 1'b1};

    rst_n = 1'b0; req_valid = 4'b1111; req_a = 32'h1234_5678; req_b = 32'h9ABC_DEF0;
    rsp_ready = 1'b1;
    step(); step();
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_A", {24'd0, A}, 32'd0);
    chk("rst_B", {24'd0, B}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("rst_rsp_sum", {24'd0, rsp_sum}, 32'd0);
    chk("rst_rsp_carry", {31'd0, rsp_carry}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    req_valid = 4'b0;
    rst_n = 1'b1;
    step();

    // Single, carry, round-robin and pointer-wrap vectors.
    for (int i = 0; i < 14; i++) apply_vec(tbl[i], 1'b0);

    // Response backpressure: five stalled cycles with everyone requesting.
    bp = '{4'b0010, 32'h0000_1200, 32'h0000_3400, 2'd1, 8'h46, 1'b0};
    apply_vec(bp, 1'b1);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_sum", {24'd0, rsp_sum}, 32'h46);
      chk("bp_rsp_id", {30'd0, rsp_id}, 32'd1);
      chk("bp_req_ready", {28'd0, req_ready}, 32'd0);
      chk("bp_A_hold", {24'd0, A}, 32'h12);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_release_busy", {31'd0, busy}, 32'd0);
    chk("bp_next_grant", {28'd0, req_ready}, 32'b0100);
    chk("bp_sum_kept", {24'd0, rsp_sum}, 32'h46);
    req_valid = 4'b0;
    step();

    // Reset one cycle into WAIT.
    req_valid = 4'b1000; req_a = 32'h0100_0000; req_b = 32'h0200_0000;
    #1;
    chk("rw_grant", {28'd0, req_ready}, 32'b1000);
    step();
    req_valid = 4'b1111;
    chk("rw_busy", {31'd0, busy}, 32'd1);
    step();
    rst_n = 1'b0;
    #1;
    chk("rw_A", {24'd0, A}, 32'd0);
    chk("rw_B", {24'd0, B}, 32'd0);
    chk("rw_busy_clr", {31'd0, busy}, 32'd0);
    chk("rw_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rw_rsp_sum", {24'd0, rsp_sum}, 32'd0);
    step(); step();
    req_valid = 4'b0;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rsp_valid) seen = 1'b1;
    end
    chk("rw_no_response", {31'd0, seen}, 32'd0);
    rv = '{4'b1010, 32'h0000_0300, 32'h0000_0400, 2'd1, 8'h07, 1'b0};
    apply_vec(rv, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
